// File: rtl/pixel_pkg.sv
// Shared types and constants for the rasterizer pixel back end.
// pixel_t carries one pixel; wr_state_t is the write-master FSM state.
package pixel_pkg;

    localparam int ADDR_W  = 26;
    localparam int COLOR_W = 24;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;

    localparam logic [3:0] PIXEL_BYTEEN = 4'b0111;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

    // Word address of screen coordinate (x, y) in a frame buffer starting at base.
    function automatic logic [ADDR_W-1:0] pixel_address(input logic [ADDR_W-1:0] base,
                                                        input int unsigned x,
                                                        input int unsigned y);
        return base + ADDR_W'(y * FB_WIDTH + x);
    endfunction

    // True when (x, y) lies inside the visible frame.
    function automatic logic pixel_in_frame(input int unsigned x, input int unsigned y);
        return (x < FB_WIDTH) && (y < FB_HEIGHT);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with one extra pointer bit to tell full from empty.
// A pop on an empty FIFO is ignored; a push on a full FIFO is only taken when
// a pop frees an entry in the same cycle.
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  pixel_t                   i_wdata,
    input  logic                     i_pop,
    output pixel_t                   o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    pixel_t           r_mem [DEPTH];
    logic [PTR_W:0]   r_wrPtr;
    logic [PTR_W:0]   r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    assign o_count  = r_wrPtr - r_rdPtr;
    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                      (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_rdata  = r_mem[r_rdPtr[PTR_W-1:0]];

    // Advance the read and write pointers; reset empties the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[PTR_W-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Pixel writer: buffers rasterizer pixels and streams them to the frame
// buffer through an Avalon-style write master. Throttles the rasterizer with
// stall_out and pulses done_out once a triangle's pixels are all accepted.
// Optional feature: define PIXEL_WRITER_STATS_EN to add the pixel_count port.
module pixel_writer
    import pixel_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int STALL_SLACK = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [25:0] addr_in,
    input  logic [23:0] color_in,
    input  logic        pixel_valid,
    input  logic        done_in,
    output logic        stall_out,
    output logic [25:0] mem_addr,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    output logic        mem_write,
    input  logic        mem_waitrequest,
    output logic        done_out,
    output logic        busy,
    output logic        overflow
`ifdef PIXEL_WRITER_STATS_EN
    ,
    output logic [31:0] pixel_count
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_t          r_state;
    wr_state_t          w_nextState;

    pixel_t             w_pixelIn;
    pixel_t             w_fifoRdata;
    logic               w_fifoFull;
    logic               w_fifoEmpty;
    logic [CNT_W-1:0]   w_fifoCount;
    logic [CNT_W-1:0]   w_countNext;
    logic [CNT_W-1:0]   w_freeNext;

    logic               w_accept;
    logic               w_pop;
    logic               w_pushAccepted;

    logic [25:0]        r_memAddr;
    logic [23:0]        r_memColor;
    logic               r_donePending;
    logic               r_stall;
    logic               r_overflow;

    assign w_pixelIn      = '{addr: addr_in, color: color_in};
    assign w_accept       = (r_state == WRITE) && !mem_waitrequest;
    assign w_pushAccepted = pixel_valid && (!w_fifoFull || w_pop);
    assign w_countNext    = w_fifoCount + CNT_W'(w_pushAccepted) - CNT_W'(w_pop);
    assign w_freeNext     = CNT_W'(FIFO_DEPTH) - w_countNext;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (pixel_valid),
        .i_wdata (w_pixelIn),
        .i_pop   (w_pop),
        .o_rdata (w_fifoRdata),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: queued pixels always go out before a pending done is reported.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (!w_fifoEmpty) begin
                    w_nextState = WRITE;
                end else if (r_donePending) begin
                    w_nextState = DONE;
                end
            end
            WRITE: begin
                if (w_accept) begin
                    if (!w_fifoEmpty) begin
                        w_nextState = WRITE;
                    end else if (r_donePending) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // FSM outputs: write strobe, byte enables, done pulse and FIFO pop.
    always_comb begin
        mem_write      = 1'b0;
        mem_byteenable = 4'b0000;
        done_out       = 1'b0;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop = !w_fifoEmpty;
            end
            WRITE: begin
                mem_write      = 1'b1;
                mem_byteenable = PIXEL_BYTEEN;
                w_pop          = w_accept && !w_fifoEmpty;
            end
            DONE: begin
                done_out = 1'b1;
            end
            default: begin
                done_out = 1'b0;
            end
        endcase
    end

    // Output registers load only on a pop, so they hold during wait states.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_memAddr  <= '0;
            r_memColor <= '0;
        end else if (w_pop) begin
            r_memAddr  <= w_fifoRdata.addr;
            r_memColor <= w_fifoRdata.color;
        end
    end

    // Done capture, registered stall from next-cycle occupancy, sticky overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_donePending <= 1'b0;
            r_stall       <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (done_in) begin
                r_donePending <= 1'b1;
            end else if (r_state == DONE) begin
                r_donePending <= 1'b0;
            end
            r_stall <= (w_freeNext <= CNT_W'(STALL_SLACK));
            if (pixel_valid && w_fifoFull && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign mem_addr      = r_memAddr;
    assign mem_writedata = {8'h00, r_memColor};
    assign stall_out     = r_stall;
    assign overflow      = r_overflow;
    assign busy          = !w_fifoEmpty || (r_state == WRITE) || r_donePending;

`ifdef PIXEL_WRITER_STATS_EN
    logic [31:0] r_pixelCount;

    // Accepted-write counter, saturating, cleared when a triangle completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pixelCount <= '0;
        end else if (r_state == DONE) begin
            r_pixelCount <= '0;
        end else if (w_accept && (r_pixelCount != 32'hFFFF_FFFF)) begin
            r_pixelCount <= r_pixelCount + 32'd1;
        end
    end

    assign pixel_count = r_pixelCount;
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Testbench for pixel_writer: randomized pixels checked against an in-order
// reference queue, plus directed latency, backpressure, done and reset cases.
`timescale 1ns/1ps
module tb_pixel_writer;
    import pixel_pkg::*;

    localparam int CLK_PERIOD = 10;
    localparam int DEPTH      = 16;
    localparam int SLACK      = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [25:0] addr_in;
    logic [23:0] color_in;
    logic        pixel_valid;
    logic        done_in;
    logic        stall_out;
    logic [25:0] mem_addr;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_write;
    logic        mem_waitrequest;
    logic        done_out;
    logic        busy;
    logic        overflow;
`ifdef PIXEL_WRITER_STATS_EN
    logic [31:0] pixel_count;
`endif

    int     checkCount = 0;
    int     passCount  = 0;
    int     cycleNum   = 0;
    int     lastAcceptCycle = -1;
    int     badUpper   = 0;
    pixel_t gotQ[$];
    pixel_t expQ[$];

    pixel_writer #(
        .FIFO_DEPTH  (DEPTH),
        .STALL_SLACK (SLACK)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .addr_in         (addr_in),
        .color_in        (color_in),
        .pixel_valid     (pixel_valid),
        .done_in         (done_in),
        .stall_out       (stall_out),
        .mem_addr        (mem_addr),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_write       (mem_write),
        .mem_waitrequest (mem_waitrequest),
        .done_out        (done_out),
        .busy            (busy),
        .overflow        (overflow)
`ifdef PIXEL_WRITER_STATS_EN
        ,
        .pixel_count     (pixel_count)
`endif
    );

    // Free-running clock.
    always #(CLK_PERIOD/2) clock = ~clock;

    // Cycle index used to relate done_out to the last accepted write.
    always @(posedge clock) cycleNum <= cycleNum + 1;

    // Memory-side monitor: log every accepted write in arrival order.
    always begin
        @(negedge clock);
        #1;
        if (reset === 1'b1 && mem_write === 1'b1 && mem_waitrequest === 1'b0) begin
            gotQ.push_back('{addr: mem_addr, color: mem_writedata[23:0]});
            lastAcceptCycle = cycleNum;
            if (mem_writedata[31:24] !== 8'h00 || mem_byteenable !== 4'b0111) badUpper++;
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before summary, want finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic drive_idle();
        pixel_valid = 1'b0;
        done_in     = 1'b0;
        addr_in     = '0;
        color_in    = '0;
    endtask

    task automatic drive_pixel(input pixel_t p);
        pixel_valid = 1'b1;
        addr_in     = p.addr;
        color_in    = p.color;
    endtask

    function automatic pixel_t rand_pixel();
        pixel_t p;
        p.addr  = pixel_address(26'($urandom_range(0, 32'h003F_0000)),
                                $urandom_range(0, FB_WIDTH - 1),
                                $urandom_range(0, FB_HEIGHT - 1));
        p.color = 24'($urandom);
        return p;
    endfunction

    // Let the DUT empty itself; ok reports whether busy fell within the bound.
    task automatic drain(input bit randWait, output bit ok);
        ok = 1'b0;
        drive_idle();
        for (int i = 0; i < 400; i++) begin
            mem_waitrequest = randWait ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        mem_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        mem_waitrequest = 1'b0;
        tick();
        tick();
        checkCount++; if (mem_write !== 1'b0) $display("[TB] FAIL reset_mem_write: got %b want 0", mem_write); else passCount++;
        checkCount++; if (mem_addr !== 26'h0) $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); else passCount++;
        checkCount++; if (mem_writedata !== 32'h0) $display("[TB] FAIL reset_mem_writedata: got %h want 0", mem_writedata); else passCount++;
        checkCount++; if (mem_byteenable !== 4'h0) $display("[TB] FAIL reset_byteenable: got %b want 0000", mem_byteenable); else passCount++;
        checkCount++; if (stall_out !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", stall_out); else passCount++;
        checkCount++; if (done_out !== 1'b0) $display("[TB] FAIL reset_done_out: got %b want 0", done_out); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCount++;
        checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b want 0", overflow); else passCount++;
        reset = 1'b1;
        tick();
        checkCount++; if (mem_write !== 1'b0) $display("[TB] FAIL reset_release_idle: got %b want 0", mem_write); else passCount++;
    endtask

    task automatic test_single_pixel();
        bit ok;
        gotQ.delete();
        mem_waitrequest = 1'b0;
        drive_pixel('{addr: 26'h100, color: 24'hFF8040});
        tick();
        drive_idle();
        checkCount++; if (mem_write !== 1'b0) $display("[TB] FAIL single_too_early: got %b want 0", mem_write); else passCount++;
        tick();
        checkCount++; if (mem_write !== 1'b1) $display("[TB] FAIL single_mem_write: got %b want 1", mem_write); else passCount++;
        checkCount++; if (mem_addr !== 26'h100) $display("[TB] FAIL single_addr: got %h want 100", mem_addr); else passCount++;
        checkCount++; if (mem_writedata !== 32'h00FF8040) $display("[TB] FAIL single_data: got %h want 00ff8040", mem_writedata); else passCount++;
        checkCount++; if (mem_byteenable !== 4'b0111) $display("[TB] FAIL single_byteen: got %b want 0111", mem_byteenable); else passCount++;
        tick();
        checkCount++; if (mem_write !== 1'b0) $display("[TB] FAIL single_one_write: got %b want 0", mem_write); else passCount++;
        checkCount++; if (mem_byteenable !== 4'b0000) $display("[TB] FAIL single_byteen_idle: got %b want 0000", mem_byteenable); else passCount++;
        drain(1'b0, ok);
        checkCount++; if (!ok) $display("[TB] FAIL single_drain: busy stayed 1, want 0"); else passCount++;
        checkCount++; if (gotQ.size() != 1) $display("[TB] FAIL single_count: got %0d writes want 1", gotQ.size()); else passCount++;
    endtask

    task automatic test_burst();
        bit     ok;
        int     bubbles;
        int     bad;
        pixel_t p;
        gotQ.delete();
        expQ.delete();
        mem_waitrequest = 1'b0;
        bubbles = 0;
        for (int i = 0; i < 8; i++) begin
            p = rand_pixel();
            expQ.push_back(p);
            drive_pixel(p);
            tick();
            if (i > 0 && mem_write !== 1'b1) bubbles++;
        end
        drive_idle();
        tick();
        if (mem_write !== 1'b1) bubbles++;
        tick();
        checkCount++; if (mem_write !== 1'b0) $display("[TB] FAIL burst_tail: got %b want 0", mem_write); else passCount++;
        checkCount++; if (bubbles != 0) $display("[TB] FAIL burst_bubbles: got %0d want 0", bubbles); else passCount++;
        drain(1'b0, ok);
        checkCount++; if (!ok) $display("[TB] FAIL burst_drain: busy stayed 1, want 0"); else passCount++;
        checkCount++; if (gotQ.size() != 8) $display("[TB] FAIL burst_count: got %0d want 8", gotQ.size()); else passCount++;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (i >= gotQ.size() || gotQ[i] !== expQ[i]) bad++;
        end
        checkCount++; if (bad != 0) $display("[TB] FAIL burst_order: got %0d wrong entries want 0", bad); else passCount++;
        checkCount++; if (badUpper != 0) $display("[TB] FAIL burst_upper_byte: got %0d bad writes want 0", badUpper); else passCount++;
    endtask

    task automatic test_wait_states();
        bit          ok;
        int          unstable;
        int          bad;
        logic [25:0] holdAddr;
        logic [31:0] holdData;
        pixel_t      p;
        gotQ.delete();
        expQ.delete();
        mem_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p = rand_pixel();
            expQ.push_back(p);
            drive_pixel(p);
            tick();
        end
        drive_idle();
        checkCount++; if (mem_write !== 1'b1) $display("[TB] FAIL wait_request_up: got %b want 1", mem_write); else passCount++;
        holdAddr = mem_addr;
        holdData = mem_writedata;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_addr !== holdAddr || mem_writedata !== holdData || mem_write !== 1'b1) unstable++;
        end
        checkCount++; if (unstable != 0) $display("[TB] FAIL wait_hold_stable: got %0d changes want 0", unstable); else passCount++;
        checkCount++; if (holdAddr !== expQ[0].addr) $display("[TB] FAIL wait_first_addr: got %h want %h", holdAddr, expQ[0].addr); else passCount++;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                p = rand_pixel();
                expQ.push_back(p);
                drive_pixel(p);
            end else begin
                pixel_valid = 1'b0;
            end
            mem_waitrequest = 1'($urandom_range(0, 1));
            tick();
        end
        drain(1'b1, ok);
        checkCount++; if (!ok) $display("[TB] FAIL wait_drain: busy stayed 1, want 0"); else passCount++;
        checkCount++; if (gotQ.size() != expQ.size()) $display("[TB] FAIL wait_count: got %0d want %0d", gotQ.size(), expQ.size()); else passCount++;
        bad = 0;
        for (int i = 0; i < expQ.size(); i++) begin
            if (i >= gotQ.size() || gotQ[i] !== expQ[i]) bad++;
        end
        checkCount++; if (bad != 0) $display("[TB] FAIL wait_order: got %0d wrong entries want 0", bad); else passCount++;
        checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL wait_no_overflow: got %b want 0", overflow); else passCount++;
    endtask

    task automatic test_done_ordering();
        bit     ok;
        int     pulses;
        int     doneCycle;
        int     bad;
        pixel_t p;
        gotQ.delete();
        expQ.delete();
        mem_waitrequest = 1'b0;
        pulses = 0;
        doneCycle = -1;
        for (int i = 0; i < 3; i++) begin
            p = rand_pixel();
            expQ.push_back(p);
            drive_pixel(p);
            done_in = (i == 2);
            tick();
        end
        drive_idle();
        for (int i = 0; i < 12; i++) begin
            if (done_out === 1'b1) begin
                pulses++;
                doneCycle = cycleNum;
            end
            tick();
        end
        checkCount++; if (pulses != 1) $display("[TB] FAIL done_pulses: got %0d want 1", pulses); else passCount++;
        checkCount++; if (doneCycle != lastAcceptCycle + 1) $display("[TB] FAIL done_timing: got cycle %0d want %0d", doneCycle, lastAcceptCycle + 1); else passCount++;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (i >= gotQ.size() || gotQ[i] !== expQ[i]) bad++;
        end
        checkCount++; if (bad != 0 || gotQ.size() != 3) $display("[TB] FAIL done_writes: got %0d writes %0d wrong, want 3 writes 0 wrong", gotQ.size(), bad); else passCount++;
`ifdef PIXEL_WRITER_STATS_EN
        checkCount++; if (pixel_count !== 32'd0) $display("[TB] FAIL stats_clear_after_done: got %0d want 0", pixel_count); else passCount++;
`endif
        drain(1'b0, ok);
        checkCount++; if (!ok) $display("[TB] FAIL done_drain: busy stayed 1, want 0"); else passCount++;
    endtask

    task automatic test_done_empty();
        bit [7:0] pat [3];
        int       expPulses [3];
        int       pulses;
        int       first;
        pat       = '{8'b0000_0001, 8'b0000_0011, 8'b0000_0101};
        expPulses = '{1, 1, 2};
        mem_waitrequest = 1'b0;
        for (int s = 0; s < 3; s++) begin
            pulses = 0;
            first  = -1;
            for (int c = 0; c < 8; c++) begin
                done_in = pat[s][c];
                tick();
                if (done_out === 1'b1) begin
                    pulses++;
                    if (first < 0) first = c;
                end
            end
            done_in = 1'b0;
            checkCount++; if (pulses != expPulses[s]) $display("[TB] FAIL done_empty_pulses_%0d: got %0d want %0d", s, pulses, expPulses[s]); else passCount++;
            checkCount++; if (first != 1) $display("[TB] FAIL done_empty_latency_%0d: got %0d want 1", s, first); else passCount++;
            checkCount++; if (busy !== 1'b0) $display("[TB] FAIL done_empty_idle_%0d: got %b want 0", s, busy); else passCount++;
        end
    endtask

    task automatic test_backpressure();
        bit     ok;
        int     held;
        int     bad;
        logic   expStall;
        pixel_t p;
        gotQ.delete();
        expQ.delete();
        mem_waitrequest = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            p = rand_pixel();
            if (k <= DEPTH + 1) expQ.push_back(p);
            drive_pixel(p);
            tick();
            // The first pixel moves to the output register at the second edge; the rest queue up.
            held = (k == 1) ? 1 : ((k - 1 > DEPTH) ? DEPTH : k - 1);
            expStall = ((DEPTH - held) <= SLACK);
            checkCount++; if (stall_out !== expStall) $display("[TB] FAIL stall_k%0d: got %b want %b", k, stall_out, expStall); else passCount++;
            if (k >= DEPTH + 1) begin
                checkCount++; if (overflow !== (k == DEPTH + 2)) $display("[TB] FAIL overflow_k%0d: got %b want %b", k, overflow, (k == DEPTH + 2)); else passCount++;
            end
        end
        drain(1'b0, ok);
        checkCount++; if (!ok) $display("[TB] FAIL bp_drain: busy stayed 1, want 0"); else passCount++;
        checkCount++; if (gotQ.size() != DEPTH + 1) $display("[TB] FAIL bp_count: got %0d want %0d", gotQ.size(), DEPTH + 1); else passCount++;
        bad = 0;
        for (int i = 0; i < expQ.size(); i++) begin
            if (i >= gotQ.size() || gotQ[i] !== expQ[i]) bad++;
        end
        checkCount++; if (bad != 0) $display("[TB] FAIL bp_order: got %0d wrong entries want 0", bad); else passCount++;
        checkCount++; if (overflow !== 1'b1) $display("[TB] FAIL bp_overflow_sticky: got %b want 1", overflow); else passCount++;
        checkCount++; if (stall_out !== 1'b0) $display("[TB] FAIL bp_stall_release: got %b want 0", stall_out); else passCount++;
    endtask

    task automatic test_async_reset();
        bit     ok;
        pixel_t p;
        gotQ.delete();
        mem_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_pixel(rand_pixel());
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        checkCount++; if (mem_write !== 1'b0) $display("[TB] FAIL areset_mem_write: got %b want 0", mem_write); else passCount++;
        checkCount++; if (mem_addr !== 26'h0) $display("[TB] FAIL areset_addr: got %h want 0", mem_addr); else passCount++;
        checkCount++; if (mem_writedata !== 32'h0) $display("[TB] FAIL areset_data: got %h want 0", mem_writedata); else passCount++;
        checkCount++; if (mem_byteenable !== 4'h0) $display("[TB] FAIL areset_byteen: got %b want 0000", mem_byteenable); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL areset_busy: got %b want 0", busy); else passCount++;
        checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL areset_overflow: got %b want 0", overflow); else passCount++;
`ifdef PIXEL_WRITER_STATS_EN
        checkCount++; if (pixel_count !== 32'd0) $display("[TB] FAIL areset_stats: got %0d want 0", pixel_count); else passCount++;
`endif
        drive_idle();
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL areset_fifo_flushed: got %b want 0", busy); else passCount++;
        gotQ.delete();
        p = rand_pixel();
        drive_pixel(p);
        tick();
        drain(1'b0, ok);
        checkCount++; if (!ok) $display("[TB] FAIL areset_drain: busy stayed 1, want 0"); else passCount++;
        checkCount++; if (gotQ.size() != 1 || gotQ[0] !== p) $display("[TB] FAIL areset_new_pixel: got %0d writes first %h want 1 write %h", gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : '0, p); else passCount++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_single_pixel();
        test_burst();
        test_wait_states();
        test_done_ordering();
        test_done_empty();
        test_backpressure();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
